// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// Pulls in state encoding, reset-cause codes and counter sizing.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    PLLRST,
    WAITLOCK,
    STABLE,
    RUN,
    HOLD
  } state_t;

  localparam logic [1:0] CAUSE_EXT      = 2'd0;
  localparam logic [1:0] CAUSE_LOCKLOSS = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
  localparam logic [1:0] CAUSE_SOFT     = 2'd3;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/rst_seq_if.sv
// PLL / system-reset bundle between the sequencer and its surroundings.
// master is the sequencer side, slave the PLL/system side.
interface rst_seq_if;

  logic       pll_locked;
  logic       sw_rst_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [1:0] cause;
  logic [7:0] lock_loss_cnt;

  modport master (
    input  pll_locked,
    input  sw_rst_req,
    output pll_rst,
    output sys_rst,
    output ready,
    output cause,
    output lock_loss_cnt
  );

  modport slave (
    output pll_locked,
    output sw_rst_req,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  cause,
    input  lock_loss_cnt
  );

endinterface

// File: rtl/sync_bit.sv
// Multi-flop single-bit synchroniser into the clk domain.
// Reusable; the flop chain is tagged for placement as a sync chain.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *)
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// PLL reset and system reset sequencer on the free-running board clock.
// Re-resets the PLL on timeout or lock loss; supports soft system reset.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int PLL_RST_CYC  = 16,
  parameter int LOCK_TIMEOUT = 100000,
  parameter int STABLE_CYC   = 1024,
  parameter int HOLD_CYC     = 64,
  parameter int SYNC_STAGES  = 2
) (
  input logic       clk,
  input logic       rst,
  rst_seq_if.master bus
);

  localparam int CW = cnt_width(
    PLL_RST_CYC, LOCK_TIMEOUT, STABLE_CYC, HOLD_CYC);

  localparam logic [CW-1:0] PLL_LAST  = CW'(PLL_RST_CYC - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);

  logic          locked_s;
  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic          pll_rst_q;
  logic          sys_rst_q;
  logic          ready_q;
  logic [1:0]    cause_q;
  logic [1:0]    cause_n;
  logic [7:0]    llc_q;
  logic [7:0]    llc_n;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (bus.pll_locked),
    .q  (locked_s)
  );

  always_comb begin
    state_n = state;
    cause_n = cause_q;
    llc_n   = llc_q;
    unique case (state)
      PLLRST: begin
        if (cnt == PLL_LAST) state_n = WAITLOCK;
      end
      WAITLOCK: begin
        if (locked_s) begin
          state_n = STABLE;
        end else if (cnt == TO_LAST) begin
          state_n = PLLRST;
          cause_n = CAUSE_TIMEOUT;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_n = PLLRST;
          cause_n = CAUSE_LOCKLOSS;
        end else if (cnt == STB_LAST) begin
          state_n = RUN;
        end
      end
      RUN: begin
        // lock loss outranks a simultaneous soft request
        if (!locked_s) begin
          state_n = PLLRST;
          cause_n = CAUSE_LOCKLOSS;
          if (llc_q != 8'hFF) llc_n = llc_q + 8'd1;
        end else if (bus.sw_rst_req) begin
          state_n = HOLD;
          cause_n = CAUSE_SOFT;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_n = PLLRST;
          cause_n = CAUSE_LOCKLOSS;
        end else if (cnt == HOLD_LAST) begin
          state_n = RUN;
        end
      end
      default: state_n = PLLRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PLLRST;
      cnt       <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      cause_q   <= CAUSE_EXT;
      llc_q     <= '0;
    end else begin
      state     <= state_n;
      // RUN has no timed exit, so the counter idles there
      if (state_n != state || state_n == RUN) cnt <= '0;
      else                                    cnt <= cnt + 1'b1;
      pll_rst_q <= (state_n == PLLRST);
      sys_rst_q <= (state_n != RUN);
      ready_q   <= (state_n == RUN);
      cause_q   <= cause_n;
      llc_q     <= llc_n;
    end
  end

  assign bus.pll_rst       = pll_rst_q;
  assign bus.sys_rst       = sys_rst_q;
  assign bus.ready         = ready_q;
  assign bus.cause         = cause_q;
  assign bus.lock_loss_cnt = llc_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer with small cycle parameters.
// Expected timing is derived arithmetically from the sequencing rules.
module tb_rst_sequencer;

  localparam int PR = 4;
  localparam int TO = 50;
  localparam int SC = 8;
  localparam int HC = 5;
  localparam int SS = 2;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [7:0] llc_exp;
  logic [1:0] cause_exp;

  rst_seq_if bus();

  rst_sequencer #(
    .PLL_RST_CYC (PR),
    .LOCK_TIMEOUT(TO),
    .STABLE_CYC  (SC),
    .HOLD_CYC    (HC),
    .SYNC_STAGES (SS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] sat(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    bus.sw_rst_req = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    llc_exp   = 8'd0;
    cause_exp = 2'd0;
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (bus.ready !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    n_cmp++;
    if (bus.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s wait_ready: ready=%b required 1", tag, bus.ready);
    end
  endtask

  task automatic bring_up();
    do_reset();
    bus.pll_locked = 1'b1;
    wait_ready("bring_up");
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    bus.sw_rst_req = 1'b0;
    repeat (3) tick();
    n_cmp += 5;
    if (bus.pll_rst !== 1'b1) begin
      n_bad++; $display("FAIL reset pll_rst: %b want 1", bus.pll_rst);
    end
    if (bus.sys_rst !== 1'b1) begin
      n_bad++; $display("FAIL reset sys_rst: %b want 1", bus.sys_rst);
    end
    if (bus.ready !== 1'b0) begin
      n_bad++; $display("FAIL reset ready: %b want 0", bus.ready);
    end
    if (bus.cause !== 2'd0) begin
      n_bad++; $display("FAIL reset cause: %0d want 0", bus.cause);
    end
    if (bus.lock_loss_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset llc: %0d want 0", bus.lock_loss_cnt);
    end
    rst = 1'b0;
  endtask

  // lock driven at t=d is seen SS+1 edges later, then STABLE_CYC to RUN
  task automatic test_powerup(input int d, input int sw_at);
    logic ep;
    logic es;
    int   last;
    do_reset();
    last = d + 1 + SS + SC;
    for (int t = 0; t <= last; t++) begin
      ep = (t < PR);
      es = (t < last);
      n_cmp += 3;
      if (bus.pll_rst !== ep) begin
        n_bad++;
        $display("FAIL powerup pll_rst t=%0d: %b want %b", t, bus.pll_rst, ep);
      end
      if (bus.sys_rst !== es) begin
        n_bad++;
        $display("FAIL powerup sys_rst t=%0d: %b want %b", t, bus.sys_rst, es);
      end
      if (bus.ready !== !es) begin
        n_bad++;
        $display("FAIL powerup ready t=%0d: %b want %b", t, bus.ready, !es);
      end
      if (t == d) bus.pll_locked = 1'b1;
      bus.sw_rst_req = (t == sw_at);
      if (t < last) tick();
    end
    n_cmp += 2;
    if (bus.cause !== 2'd0) begin
      n_bad++; $display("FAIL powerup cause: %0d want 0", bus.cause);
    end
    if (bus.lock_loss_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL powerup llc: %0d want 0", bus.lock_loss_cnt);
    end
  endtask

  task automatic test_timeout();
    int per;
    logic [1:0] ec;
    do_reset();
    per = PR + TO;
    for (int t = 0; t <= 3 * per + PR; t++) begin
      ec = (t >= per) ? 2'd2 : 2'd0;
      n_cmp += 3;
      if (bus.pll_rst !== ((t % per) < PR)) begin
        n_bad++;
        $display("FAIL timeout pll_rst t=%0d: %b want %b",
                 t, bus.pll_rst, ((t % per) < PR));
      end
      if (bus.sys_rst !== 1'b1) begin
        n_bad++;
        $display("FAIL timeout sys_rst t=%0d: %b want 1", t, bus.sys_rst);
      end
      if (bus.cause !== ec) begin
        n_bad++;
        $display("FAIL timeout cause t=%0d: %0d want %0d", t, bus.cause, ec);
      end
      tick();
    end
  endtask

  // called in RUN; lock low for dur cycles
  task automatic test_lockloss(input int dur);
    int e;
    int last;
    logic es;
    logic ep;
    logic [7:0] el;
    logic [1:0] ec;
    e = (dur + SS + 1 > PR + 4) ? dur + SS + 1 : PR + 4;
    last = e + SC;
    bus.pll_locked = 1'b0;
    for (int t = 0; t <= last; t++) begin
      if (t == dur) bus.pll_locked = 1'b1;
      es = (t >= SS + 1) && (t < last);
      ep = (t >= SS + 1) && (t < SS + 1 + PR);
      el = (t >= SS + 1) ? sat(llc_exp) : llc_exp;
      ec = (t >= SS + 1) ? 2'd1 : cause_exp;
      n_cmp += 4;
      if (bus.sys_rst !== es) begin
        n_bad++;
        $display("FAIL lockloss sys_rst t=%0d: %b want %b", t, bus.sys_rst, es);
      end
      if (bus.pll_rst !== ep) begin
        n_bad++;
        $display("FAIL lockloss pll_rst t=%0d: %b want %b", t, bus.pll_rst, ep);
      end
      if (bus.lock_loss_cnt !== el) begin
        n_bad++;
        $display("FAIL lockloss llc t=%0d: %0d want %0d",
                 t, bus.lock_loss_cnt, el);
      end
      if (bus.cause !== ec) begin
        n_bad++;
        $display("FAIL lockloss cause t=%0d: %0d want %0d", t, bus.cause, ec);
      end
      if (t < last) tick();
    end
    llc_exp   = sat(llc_exp);
    cause_exp = 2'd1;
  endtask

  task automatic test_soft();
    logic es;
    logic [1:0] ec;
    bus.sw_rst_req = 1'b1;
    for (int t = 0; t <= HC + 1; t++) begin
      if (t == 1) bus.sw_rst_req = 1'b0;
      es = (t >= 1) && (t <= HC);
      ec = (t >= 1) ? 2'd3 : cause_exp;
      n_cmp += 3;
      if (bus.sys_rst !== es) begin
        n_bad++;
        $display("FAIL soft sys_rst t=%0d: %b want %b", t, bus.sys_rst, es);
      end
      if (bus.pll_rst !== 1'b0) begin
        n_bad++;
        $display("FAIL soft pll_rst t=%0d: %b want 0", t, bus.pll_rst);
      end
      if (bus.cause !== ec) begin
        n_bad++;
        $display("FAIL soft cause t=%0d: %0d want %0d", t, bus.cause, ec);
      end
      if (t <= HC) tick();
    end
    cause_exp = 2'd3;
    // lock loss during HOLD is not counted
    bus.sw_rst_req = 1'b1;
    tick();
    bus.sw_rst_req = 1'b0;
    bus.pll_locked = 1'b0;
    repeat (SS + 1) tick();
    n_cmp += 3;
    if (bus.pll_rst !== 1'b1) begin
      n_bad++; $display("FAIL soft_hold pll_rst: %b want 1", bus.pll_rst);
    end
    if (bus.cause !== 2'd1) begin
      n_bad++; $display("FAIL soft_hold cause: %0d want 1", bus.cause);
    end
    if (bus.lock_loss_cnt !== llc_exp) begin
      n_bad++;
      $display("FAIL soft_hold llc: %0d want %0d", bus.lock_loss_cnt, llc_exp);
    end
    cause_exp = 2'd1;
    bus.pll_locked = 1'b1;
    wait_ready("soft_hold");
  endtask

  task automatic test_collide();
    bus.pll_locked = 1'b0;
    repeat (SS) tick();
    bus.sw_rst_req = 1'b1;
    tick();
    bus.sw_rst_req = 1'b0;
    llc_exp = sat(llc_exp);
    n_cmp += 3;
    if (bus.pll_rst !== 1'b1) begin
      n_bad++; $display("FAIL collide pll_rst: %b want 1", bus.pll_rst);
    end
    if (bus.cause !== 2'd1) begin
      n_bad++; $display("FAIL collide cause: %0d want 1", bus.cause);
    end
    if (bus.lock_loss_cnt !== llc_exp) begin
      n_bad++;
      $display("FAIL collide llc: %0d want %0d", bus.lock_loss_cnt, llc_exp);
    end
    cause_exp = 2'd1;
    bus.pll_locked = 1'b1;
    wait_ready("collide");
  endtask

  task automatic test_saturate();
    int dur;
    for (int i = 0; i < 300; i++) begin
      dur = $urandom_range(1, 3);
      bus.pll_locked = 1'b0;
      for (int k = 1; k <= SS + 1; k++) begin
        tick();
        if (k == dur) bus.pll_locked = 1'b1;
      end
      llc_exp = sat(llc_exp);
      n_cmp += 2;
      if (bus.ready !== 1'b0) begin
        n_bad++; $display("FAIL sat ready i=%0d: %b want 0", i, bus.ready);
      end
      if (bus.lock_loss_cnt !== llc_exp) begin
        n_bad++;
        $display("FAIL sat llc i=%0d: %0d want %0d",
                 i, bus.lock_loss_cnt, llc_exp);
      end
      wait_ready("sat");
    end
    // land in mid-STABLE, then apply rst
    bus.pll_locked = 1'b0;
    tick();
    bus.pll_locked = 1'b1;
    repeat (9) tick();
    n_cmp += 2;
    if (bus.pll_rst !== 1'b0 || bus.sys_rst !== 1'b1) begin
      n_bad++;
      $display("FAIL midstable outputs: pll_rst=%b sys_rst=%b want 0/1",
               bus.pll_rst, bus.sys_rst);
    end
    if (bus.lock_loss_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL midstable llc: %0d want 255", bus.lock_loss_cnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    llc_exp   = 8'd0;
    cause_exp = 2'd0;
    n_cmp += 4;
    if (bus.sys_rst !== 1'b1 || bus.ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid sys_rst/ready: %b/%b want 1/0",
               bus.sys_rst, bus.ready);
    end
    if (bus.lock_loss_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL rst_mid llc: %0d want 0", bus.lock_loss_cnt);
    end
    if (bus.cause !== 2'd0) begin
      n_bad++; $display("FAIL rst_mid cause: %0d want 0", bus.cause);
    end
    if (bus.pll_rst !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid pll_rst: %b want 1", bus.pll_rst);
    end
    // counter restarted: full PR-cycle pulse follows
    for (int u = 1; u <= PR; u++) begin
      tick();
      n_cmp++;
      if (bus.pll_rst !== (u < PR)) begin
        n_bad++;
        $display("FAIL rst_mid cnt u=%0d: pll_rst=%b want %b",
                 u, bus.pll_rst, (u < PR));
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    llc_exp = 8'd0;
    cause_exp = 2'd0;
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    bus.sw_rst_req = 1'b0;
    test_reset();
    test_powerup(10, -1);
    test_powerup($urandom_range(4, 40), -1);
    test_powerup(10, 6);
    test_timeout();
    bring_up();
    test_lockloss(3);
    repeat (4) test_lockloss($urandom_range(1, 5));
    test_soft();
    test_collide();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
